gemm_tile_scheduler: RTL and testbench

Job-level sequencer that walks an arbitrary dim_M × dim_N × dim_K GEMM over the M×N output-stationary systolic tile path. For each output tile it requests operand loading, pulses the tile driver's start with the tile's K length, waits for the tile to complete, then requests result write-back. It sits between the host/command decoder and the tile load unit, tile driver and result store unit.

---
 rtl/gemm_tile_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_gemm_tile_scheduler.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_scheduler.sv
// ---------------------------------------------------------------------------
// gemm_tile_scheduler
//
// Walks a dim_M x dim_N x dim_K GEMM job over an M x N output-stationary
// tile path. For each output tile it requests an operand load, pulses the
// tile driver with the job's K length, waits for tile completion and then
// requests result write-back. The tile order is row-major, with column tiles
// innermost.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_job_start               one-cycle job request, sampled only in idle
//   i_dim_m/i_dim_n/i_dim_k   job dimensions, latched on accept
//   o_job_busy                job in progress
//   o_job_done, o_job_err     one-cycle completion pulse, error qualifier
//   o_tiles_done              tiles stored in current/last job
//   o_ld_req / i_ld_ack       operand load handshake
//   o_ld_row_base/col_base    first output row/column of the current tile
//   o_ld_rows / o_ld_cols     valid rows/columns of the current tile
//   o_ld_k_len                latched K
//   o_tile_start, o_tile_k_len, i_tile_done   tile driver interface
//   o_st_req / i_st_ack       result store handshake (same tile address)
// ---------------------------------------------------------------------------
module gemm_tile_scheduler #(
    parameter int unsigned M    = 8,
    parameter int unsigned N    = 8,
    parameter int unsigned KMAX = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_job_start,
    input  logic [15:0]                i_dim_m,
    input  logic [15:0]                i_dim_n,
    input  logic [15:0]                i_dim_k,
    output logic                       o_job_busy,
    output logic                       o_job_done,
    output logic                       o_job_err,
    output logic [15:0]                o_tiles_done,
    output logic                       o_ld_req,
    input  logic                       i_ld_ack,
    output logic [15:0]                o_ld_row_base,
    output logic [15:0]                o_ld_col_base,
    output logic [$clog2(M+1)-1:0]     o_ld_rows,
    output logic [$clog2(N+1)-1:0]     o_ld_cols,
    output logic [15:0]                o_ld_k_len,
    output logic                       o_tile_start,
    output logic [15:0]                o_tile_k_len,
    input  logic                       i_tile_done,
    output logic                       o_st_req,
    input  logic                       i_st_ack
);

    localparam int unsigned RW = $clog2(M + 1);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StWait,
        StStore,
        StNext,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [15:0] r_dim_m;
    logic [15:0] r_dim_n;
    logic [15:0] r_dim_k;
    // 17-bit bases so base + tile size never wraps for any 16-bit dimension.
    logic [16:0] r_row_base;
    logic [16:0] r_col_base;
    logic [15:0] r_tiles_done;
    logic        r_err;

    logic        w_accept;
    logic        w_reject;
    logic        w_zero_dim;
    logic [16:0] w_col_step;
    logic [16:0] w_row_step;
    logic        w_col_wrap;
    logic        w_last_row;
    logic        w_job_end;
    logic [16:0] w_row_rem;
    logic [16:0] w_col_rem;

    assign w_accept   = (r_state == StIdle) && i_job_start;
    assign w_reject   = 32'(i_dim_k) > KMAX;
    assign w_zero_dim = (i_dim_m == 16'd0) || (i_dim_n == 16'd0) || (i_dim_k == 16'd0);

    assign w_col_step = r_col_base + 17'(N);
    assign w_row_step = r_row_base + 17'(M);
    assign w_col_wrap = w_col_step >= {1'b0, r_dim_n};
    assign w_last_row = w_row_step >= {1'b0, r_dim_m};
    assign w_job_end  = w_col_wrap && w_last_row;

    // Remaining extent from the current base; bases never pass the dims.
    assign w_row_rem  = {1'b0, r_dim_m} - r_row_base;
    assign w_col_rem  = {1'b0, r_dim_n} - r_col_base;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_job_start) begin
                    if (w_reject || w_zero_dim) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StLoad;
                    end
                end
            end
            StLoad: begin
                if (i_ld_ack) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_state_next = StWait;
            end
            StWait: begin
                if (i_tile_done) begin
                    w_state_next = StStore;
                end
            end
            StStore: begin
                if (i_st_ack) begin
                    w_state_next = StNext;
                end
            end
            StNext: begin
                w_state_next = w_job_end ? StDone : StLoad;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Job datapath: latched dims, tile bases, tile counter, error cause
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dim_m      <= 16'd0;
            r_dim_n      <= 16'd0;
            r_dim_k      <= 16'd0;
            r_row_base   <= 17'd0;
            r_col_base   <= 17'd0;
            r_tiles_done <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dim_m      <= i_dim_m;
                r_dim_n      <= i_dim_n;
                r_dim_k      <= i_dim_k;
                r_row_base   <= 17'd0;
                r_col_base   <= 17'd0;
                r_tiles_done <= 16'd0;
                r_err        <= w_reject;
            end
            if ((r_state == StStore) && i_st_ack) begin
                r_tiles_done <= r_tiles_done + 16'd1;
            end
            // The last tile's address is kept after the job ends.
            if ((r_state == StNext) && !w_job_end) begin
                if (w_col_wrap) begin
                    r_col_base <= 17'd0;
                    r_row_base <= w_row_step;
                end else begin
                    r_col_base <= w_col_step;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_job_busy    = 1'b0;
        o_job_done    = 1'b0;
        o_job_err     = 1'b0;
        o_ld_req      = 1'b0;
        o_tile_start  = 1'b0;
        o_st_req      = 1'b0;
        unique case (r_state)
            StIdle:  ;
            StLoad: begin
                o_job_busy = 1'b1;
                o_ld_req   = 1'b1;
            end
            StRun: begin
                o_job_busy   = 1'b1;
                o_tile_start = 1'b1;
            end
            StWait: begin
                o_job_busy = 1'b1;
            end
            StStore: begin
                o_job_busy = 1'b1;
                o_st_req   = 1'b1;
            end
            StNext: begin
                o_job_busy = 1'b1;
            end
            StDone: begin
                o_job_done = 1'b1;
                o_job_err  = r_err;
            end
            default: ;
        endcase

        o_tiles_done  = r_tiles_done;
        o_ld_row_base = r_row_base[15:0];
        o_ld_col_base = r_col_base[15:0];
        o_ld_k_len    = r_dim_k;
        o_tile_k_len  = r_dim_k;

        if (w_row_rem >= 17'(M)) begin
            o_ld_rows = RW'(M);
        end else begin
            o_ld_rows = w_row_rem[RW-1:0];
        end
        if (w_col_rem >= 17'(N)) begin
            o_ld_cols = CW'(N);
        end else begin
            o_ld_cols = w_col_rem[CW-1:0];
        end
    end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gemm_tile_scheduler
//
// Scoreboard bench: each job pushes its hand-computed tile sequence and job
// completion record into queues; a monitor pops and compares on every
// tile_start and job_done. A responder process plays load unit, tile driver
// and store unit with configurable handshake delays.
// ---------------------------------------------------------------------------
module tb_gemm_tile_scheduler;

    logic        clk;
    logic        rst_n;
    logic        job_start;
    logic [15:0] dim_m;
    logic [15:0] dim_n;
    logic [15:0] dim_k;
    logic        job_busy;
    logic        job_done;
    logic        job_err;
    logic [15:0] tiles_done;
    logic        ld_req;
    logic        ld_ack;
    logic [15:0] ld_row_base;
    logic [15:0] ld_col_base;
    logic [3:0]  ld_rows;
    logic [3:0]  ld_cols;
    logic [15:0] ld_k_len;
    logic        tile_start;
    logic [15:0] tile_k_len;
    logic        tile_done;
    logic        st_req;
    logic        st_ack;

    gemm_tile_scheduler #(
        .M   (8),
        .N   (8),
        .KMAX(1024)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_job_start  (job_start),
        .i_dim_m      (dim_m),
        .i_dim_n      (dim_n),
        .i_dim_k      (dim_k),
        .o_job_busy   (job_busy),
        .o_job_done   (job_done),
        .o_job_err    (job_err),
        .o_tiles_done (tiles_done),
        .o_ld_req     (ld_req),
        .i_ld_ack     (ld_ack),
        .o_ld_row_base(ld_row_base),
        .o_ld_col_base(ld_col_base),
        .o_ld_rows    (ld_rows),
        .o_ld_cols    (ld_cols),
        .o_ld_k_len   (ld_k_len),
        .o_tile_start (tile_start),
        .o_tile_k_len (tile_k_len),
        .i_tile_done  (tile_done),
        .o_st_req     (st_req),
        .i_st_ack     (st_ack)
    );

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [3:0]  rows;
        logic [3:0]  cols;
        logic [15:0] k;
    } tile_t;

    typedef struct packed {
        logic        err;
        logic [15:0] tiles;
    } job_t;

    tile_t tile_q[$];
    job_t  job_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ts_cnt = 0;
    int done_cnt = 0;

    // Responder behaviour knobs
    bit rand_delay = 0;
    bit spurious   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tile(input int r, input int c, input int rows, input int cols,
                             input int k);
        tile_t t;
        t.row  = 16'(r);
        t.col  = 16'(c);
        t.rows = 4'(rows);
        t.cols = 4'(cols);
        t.k    = 16'(k);
        tile_q.push_back(t);
    endtask

    task automatic push_job(input bit err, input int tiles);
        job_t j;
        j.err   = err;
        j.tiles = 16'(tiles);
        job_q.push_back(j);
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin
        tile_t t;
        job_t  j;
        logic        prev_ld_req;
        logic [15:0] cur_row;
        logic [15:0] cur_col;
        prev_ld_req = 1'b0;
        cur_row = 16'd0;
        cur_col = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ld_req = 1'b0;
                continue;
            end
            if (tile_start) begin
                ts_cnt++;
                check("tile_start_after_ld", {prev_ld_req, ld_req}, 2'b10);
                if (tile_q.size() == 0) begin
                    check("unexpected_tile_start", 32'(ld_row_base), 32'hFFFF_FFFF);
                end else begin
                    t = tile_q.pop_front();
                    check("tile_row_base", 32'(ld_row_base), 32'(t.row));
                    check("tile_col_base", 32'(ld_col_base), 32'(t.col));
                    check("tile_rows", 32'(ld_rows), 32'(t.rows));
                    check("tile_cols", 32'(ld_cols), 32'(t.cols));
                    check("tile_k_len", 32'(tile_k_len), 32'(t.k));
                    check("ld_k_len", 32'(ld_k_len), 32'(t.k));
                end
                cur_row = ld_row_base;
                cur_col = ld_col_base;
            end
            if (st_req) begin
                check("store_row_stable", 32'(ld_row_base), 32'(cur_row));
                check("store_col_stable", 32'(ld_col_base), 32'(cur_col));
            end
            if (job_done) begin
                done_cnt++;
                check("done_busy_low", 32'(job_busy), 32'd0);
                if (job_q.size() == 0) begin
                    check("unexpected_job_done", 32'(tiles_done), 32'hFFFF_FFFF);
                end else begin
                    j = job_q.pop_front();
                    check("job_err", 32'(job_err), 32'(j.err));
                    check("job_tiles_done", 32'(tiles_done), 32'(j.tiles));
                end
            end
            prev_ld_req = ld_req;
        end
    end

    // -----------------------------------------------------------------------
    // Responder: load unit, tile driver, store unit
    // -----------------------------------------------------------------------
    initial begin
        bit ld_arm;
        bit st_arm;
        int ld_cnt;
        int st_cnt;
        int tile_cnt;
        ld_arm = 0;
        st_arm = 0;
        ld_cnt = 0;
        st_cnt = 0;
        tile_cnt = 0;
        ld_ack = 1'b0;
        st_ack = 1'b0;
        tile_done = 1'b0;
        forever begin
            @(negedge clk);
            ld_ack    = 1'b0;
            st_ack    = 1'b0;
            tile_done = 1'b0;
            if (!rst_n) begin
                ld_arm = 0;
                st_arm = 0;
                tile_cnt = 0;
                continue;
            end
            if (ld_req) begin
                if (!ld_arm) begin
                    ld_arm = 1;
                    ld_cnt = rand_delay ? int'($urandom_range(0, 7)) : 0;
                    if (spurious) tile_done = 1'b1;
                end
                if (ld_cnt == 0) ld_ack = 1'b1;
                else ld_cnt--;
            end else begin
                ld_arm = 0;
            end
            if (tile_start) begin
                tile_cnt = 10;
            end else if (tile_cnt > 0) begin
                tile_cnt--;
                if (tile_cnt == 0) tile_done = 1'b1;
            end
            if (st_req) begin
                if (!st_arm) begin
                    st_arm = 1;
                    st_cnt = rand_delay ? int'($urandom_range(0, 7)) : 0;
                end
                if (st_cnt == 0) st_ack = 1'b1;
                else st_cnt--;
            end else begin
                st_arm = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic issue(input int m, input int n, input int k, input bit runs);
        @(negedge clk);
        dim_m = 16'(m);
        dim_n = 16'(n);
        dim_k = 16'(k);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("accept_busy", 32'(job_busy), 32'(runs));
        check("accept_ld_req", 32'(ld_req), 32'(runs));
        check("accept_done", 32'(job_done), 32'(!runs));
        check("accept_tiles_clr", 32'(tiles_done), 32'd0);
    endtask

    task automatic wait_done(input int start);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt > start) break;
        end
        if (i == 3000) check("job_done_timeout", 32'(done_cnt), 32'(start + 1));
    endtask

    task automatic wait_tiles(input int target);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (ts_cnt >= target) break;
        end
        if (i == 3000) check("tile_start_timeout", 32'(ts_cnt), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(job_busy), 32'd0);
        check({tag, "_done"}, 32'(job_done), 32'd0);
        check({tag, "_err"}, 32'(job_err), 32'd0);
        check({tag, "_tiles"}, 32'(tiles_done), 32'd0);
        check({tag, "_ld_req"}, 32'(ld_req), 32'd0);
        check({tag, "_row_base"}, 32'(ld_row_base), 32'd0);
        check({tag, "_col_base"}, 32'(ld_col_base), 32'd0);
        check({tag, "_rows"}, 32'(ld_rows), 32'd0);
        check({tag, "_cols"}, 32'(ld_cols), 32'd0);
        check({tag, "_ld_k"}, 32'(ld_k_len), 32'd0);
        check({tag, "_tile_start"}, 32'(tile_start), 32'd0);
        check({tag, "_tile_k"}, 32'(tile_k_len), 32'd0);
        check({tag, "_st_req"}, 32'(st_req), 32'd0);
    endtask

    initial begin
        int start;
        rst_n = 1'b0;
        job_start = 1'b0;
        dim_m = 16'd0;
        dim_n = 16'd0;
        dim_k = 16'd0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single full tile
        push_tile(0, 0, 8, 8, 4);
        push_job(0, 1);
        start = done_cnt;
        issue(8, 8, 4, 1);
        wait_done(start);

        // 3 x 2 tiles with partial edge tiles
        push_tile(0, 0, 8, 8, 16);
        push_tile(0, 8, 8, 4, 16);
        push_tile(8, 0, 8, 8, 16);
        push_tile(8, 8, 8, 4, 16);
        push_tile(16, 0, 4, 8, 16);
        push_tile(16, 8, 4, 4, 16);
        push_job(0, 6);
        start = done_cnt;
        issue(20, 12, 16, 1);
        wait_done(start);

        // K above the limit is rejected
        push_job(1, 0);
        start = done_cnt;
        issue(8, 8, 1025, 0);
        wait_done(start);
        check("reject_no_ld_req", 32'(ld_req), 32'd0);

        // Zero dimension completes with no tiles and no error
        push_job(0, 0);
        start = done_cnt;
        issue(5, 0, 3, 0);
        wait_done(start);

        // Random handshake delays plus spurious tile_done in LOAD
        rand_delay = 1;
        spurious = 1;
        push_tile(0, 0, 8, 8, 3);
        push_tile(0, 8, 8, 8, 3);
        push_tile(0, 16, 8, 1, 3);
        push_tile(8, 0, 1, 8, 3);
        push_tile(8, 8, 1, 8, 3);
        push_tile(8, 16, 1, 1, 3);
        push_job(0, 6);
        start = done_cnt;
        issue(9, 17, 3, 1);
        wait_done(start);
        rand_delay = 0;
        spurious = 0;

        // job_start while busy is ignored
        push_tile(0, 0, 8, 8, 2);
        push_tile(0, 8, 8, 8, 2);
        push_job(0, 2);
        start = done_cnt;
        issue(8, 16, 2, 1);
        wait_tiles(ts_cnt + 1);
        @(negedge clk);
        dim_m = 16'd8;
        dim_n = 16'd8;
        dim_k = 16'd5;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("busy_ignore_busy", 32'(job_busy), 32'd1);
        check("busy_ignore_tiles", 32'(tiles_done), 32'd0);
        check("busy_ignore_k", 32'(tile_k_len), 32'd2);
        wait_done(start);

        // Reset during WAIT of the second tile
        push_tile(0, 0, 8, 8, 16);
        push_tile(0, 8, 8, 4, 16);
        push_job(0, 6);
        start = ts_cnt;
        issue(20, 12, 16, 1);
        wait_tiles(start + 2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        tile_q.delete();
        job_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean job after reset release
        push_tile(0, 0, 8, 8, 4);
        push_job(0, 1);
        start = done_cnt;
        issue(8, 8, 4, 1);
        wait_done(start);

        repeat (5) @(negedge clk);
        check("tile_q_empty", 32'(tile_q.size()), 32'd0);
        check("job_q_empty", 32'(job_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
